// File: rtl/ps2_transmitter.sv
// rtl/ps2_transmitter.sv - host-to-device PS/2 command transmitter with open-drain line control
module ps2_transmitter #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       kclk,
  input  logic       kdata,
  output logic       kclk_drive_low,
  output logic       kdata_drive_low,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_ack_err,
  output logic       tx_timeout
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int FLT_W   = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [8:0]       sh_q, sh_d;
  logic             kdata_low_q, kdata_low_d;
  logic             ack_err_q, ack_err_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             to_q, to_d;

  logic [1:0]       clk_sync_q, data_sync_q;
  logic [FLT_W-1:0] clk_flt_cnt_q, data_flt_cnt_q;
  logic             fclk_q, fdata_q, fclk_prev_q;
  logic             fclk_fall;
  logic             wd_expired;

  // Two-flop synchronizers for the raw pins; idle line level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], kclk};
      data_sync_q <= {data_sync_q[0], kdata};
    end
  end

  // Clock glitch filter: a new level must persist FILTER_LEN samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      fclk_q        <= 1'b1;
      clk_flt_cnt_q <= '0;
    end else if (clk_sync_q[1] != fclk_q) begin
      if (clk_flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
        fclk_q        <= clk_sync_q[1];
        clk_flt_cnt_q <= '0;
      end else begin
        clk_flt_cnt_q <= clk_flt_cnt_q + 1'b1;
      end
    end else begin
      clk_flt_cnt_q <= '0;
    end
  end

  // Data glitch filter, same rule as the clock filter.
  always_ff @(posedge clk) begin
    if (rst) begin
      fdata_q        <= 1'b1;
      data_flt_cnt_q <= '0;
    end else if (data_sync_q[1] != fdata_q) begin
      if (data_flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
        fdata_q        <= data_sync_q[1];
        data_flt_cnt_q <= '0;
      end else begin
        data_flt_cnt_q <= data_flt_cnt_q + 1'b1;
      end
    end else begin
      data_flt_cnt_q <= '0;
    end
  end

  // Previous filtered clock level for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) fclk_prev_q <= 1'b1;
    else     fclk_prev_q <= fclk_q;
  end

  assign fclk_fall  = fclk_prev_q & ~fclk_q;
  assign wd_expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      sh_q        <= '0;
      kdata_low_q <= 1'b0;
      ack_err_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      to_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      sh_q        <= sh_d;
      kdata_low_q <= kdata_low_d;
      ack_err_q   <= ack_err_d;
      done_q      <= done_d;
      err_q       <= err_d;
      to_q        <= to_d;
    end
  end

  // Next-state logic: inhibit, request-to-send, bit shifting, ack and watchdog.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    sh_d        = sh_q;
    kdata_low_d = kdata_low_q;
    ack_err_d   = ack_err_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    to_d        = 1'b0;
    case (state_q)
      IDLE: begin
        kdata_low_d = 1'b0;
        if (tx_valid) begin
          sh_d    = {~^tx_data, tx_data};
          cnt_d   = '0;
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        if (kdata_low_q) begin
          // Transition cycle: start bit already driven, now free the clock.
          cnt_d   = '0;
          bit_d   = '0;
          state_d = RTS;
        end else if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
          kdata_low_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RTS: begin
        if (fclk_fall) begin
          cnt_d = '0;
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd9) begin
            kdata_low_d = 1'b0;
            state_d     = ACK;
          end else begin
            kdata_low_d = ~sh_q[0];
            sh_d        = {1'b0, sh_q[8:1]};
          end
        end else if (wd_expired) begin
          kdata_low_d = 1'b0;
          to_d        = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACK: begin
        if (fclk_fall) begin
          ack_err_d = fdata_q;
          cnt_d     = '0;
          state_d   = WAIT_IDLE;
        end else if (wd_expired) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (fclk_q && fdata_q) begin
          done_d  = ~ack_err_q;
          err_d   = ack_err_q;
          state_d = IDLE;
        end else if (fclk_fall) begin
          cnt_d = '0;
        end else if (wd_expired) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        kdata_low_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  assign tx_ready        = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign kclk_drive_low  = (state_q == INHIBIT);
  assign kdata_drive_low = kdata_low_q;
  assign tx_done         = done_q;
  assign tx_ack_err      = err_q;
  assign tx_timeout      = to_q;

endmodule

// File: tb/tb_ps2_transmitter.sv
// tb/tb_ps2_transmitter.sv - directed table-driven bench for ps2_transmitter
module tb_ps2_transmitter;

  localparam int INH = 200;
  localparam int TO  = 2000;
  localparam int FL  = 8;
  localparam int H   = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       kclk, kdata;
  logic       kclk_drive_low, kdata_drive_low;
  logic       busy, tx_done, tx_ack_err, tx_timeout;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  int tests = 0;
  int failures = 0;

  assign kclk  = dev_clk & ~kclk_drive_low;
  assign kdata = dev_data & ~kdata_drive_low;

  ps2_transmitter #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN(FL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .kclk(kclk),
    .kdata(kdata),
    .kclk_drive_low(kclk_drive_low),
    .kdata_drive_low(kdata_drive_low),
    .busy(busy),
    .tx_done(tx_done),
    .tx_ack_err(tx_ack_err),
    .tx_timeout(tx_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL global_time_limit: got expired expected finished");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] data;
    logic       ack_high;
    logic       glitch;
    logic       poke;
    logic       exp_par;
    int         exp_res;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // res: 0 none, 1 done, 2 ack error, 3 timeout, 4 reset abort
  task automatic run_frame(input logic [7:0] d, input logic ack_high, input logic glitch,
                           input logic poke, input int stop_edge, input int rst_edge,
                           output logic [10:0] bits, output int inh, output int tr,
                           output int res, output int dly);
    int  n;
    bit  aborted;
    bits = '0; inh = 0; tr = 0; res = 0; dly = 0; aborted = 0;
    @(negedge clk);
    check("ready_before", tx_ready, 1);
    tx_data = d; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0; tx_data = 8'h00;
    n = 0;
    while (kclk_drive_low && n < INH + 50) begin
      if (kdata_drive_low) tr++; else inh++;
      n++;
      @(negedge clk);
    end
    check("start_held", kdata_drive_low, 1);
    for (int i = 0; i <= 10 && !aborted; i++) begin
      dev_clk = 1'b1;
      repeat (H / 2) @(negedge clk);
      bits[i] = ~kdata_drive_low;
      if (i == 10 && !ack_high) dev_data = 1'b0;
      if (poke && i == 5) begin tx_data = 8'h55; tx_valid = 1'b1; end
      if (glitch && i == 3) begin
        dev_clk = 1'b0;
        repeat (3) @(negedge clk);
        dev_clk = 1'b1;
        repeat (H / 2 - 3) @(negedge clk);
      end else begin
        repeat (H / 2) @(negedge clk);
      end
      tx_valid = 1'b0;
      dev_clk = 1'b0;
      if (i + 1 == stop_edge) begin
        aborted = 1;
        n = 0;
        while (!tx_timeout && n < TO + 100) begin
          @(negedge clk);
          n++;
        end
        dly = n;
        res = tx_timeout ? 3 : 0;
      end else if (i + 1 == rst_edge) begin
        aborted = 1;
        repeat (H / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_kclk_rel", kclk_drive_low, 0);
        check("rst_kdata_rel", kdata_drive_low, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {tx_done, tx_ack_err, tx_timeout}, 0);
        res = 4;
      end else begin
        repeat (H) @(negedge clk);
      end
    end
    dev_clk = 1'b1;
    dev_data = 1'b1;
    if (!aborted) begin
      n = 0;
      while (!(tx_done || tx_ack_err || tx_timeout) && n < 300) begin
        @(negedge clk);
        n++;
      end
      res = tx_done ? 1 : (tx_ack_err ? 2 : (tx_timeout ? 3 : 0));
    end
    if (res != 4) begin
      @(negedge clk);
      check("pulse_one_cycle", {tx_done, tx_ack_err, tx_timeout}, 0);
    end
  endtask

  logic [10:0] bits;
  int inh, tr, res, dly, cnt;

  initial begin
    vecs[0] = '{data: 8'hED, ack_high: 1'b0, glitch: 1'b0, poke: 1'b0, exp_par: 1'b1, exp_res: 1};
    vecs[1] = '{data: 8'h01, ack_high: 1'b0, glitch: 1'b0, poke: 1'b0, exp_par: 1'b0, exp_res: 1};
    vecs[2] = '{data: 8'hFF, ack_high: 1'b0, glitch: 1'b0, poke: 1'b0, exp_par: 1'b1, exp_res: 1};
    vecs[3] = '{data: 8'h00, ack_high: 1'b0, glitch: 1'b0, poke: 1'b0, exp_par: 1'b1, exp_res: 1};
    vecs[4] = '{data: 8'hF4, ack_high: 1'b1, glitch: 1'b0, poke: 1'b0, exp_par: 1'b0, exp_res: 2};
    vecs[5] = '{data: 8'hA5, ack_high: 1'b0, glitch: 1'b1, poke: 1'b1, exp_par: 1'b1, exp_res: 1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", tx_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_drives", {kclk_drive_low, kdata_drive_low}, 0);
    check("reset_pulses", {tx_done, tx_ack_err, tx_timeout}, 0);
    repeat (20) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].data, vecs[v].ack_high, vecs[v].glitch, vecs[v].poke, 0, 0,
                bits, inh, tr, res, dly);
      check($sformatf("v%0d_inhibit_len", v), inh, INH);
      check($sformatf("v%0d_transition", v), tr, 1);
      check($sformatf("v%0d_start_bit", v), bits[0], 0);
      check($sformatf("v%0d_data_bits", v), bits[8:1], vecs[v].data);
      check($sformatf("v%0d_parity", v), bits[9], vecs[v].exp_par);
      check($sformatf("v%0d_stop", v), bits[10], 1);
      check($sformatf("v%0d_result", v), res, vecs[v].exp_res);
      check($sformatf("v%0d_busy_after", v), busy, 0);
      cnt = 0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (kclk_drive_low || busy) cnt++;
      end
      check($sformatf("v%0d_no_extra_frame", v), cnt, 0);
    end

    // Device stops clocking after its fourth falling edge.
    run_frame(8'h12, 1'b0, 1'b0, 1'b0, 4, 0, bits, inh, tr, res, dly);
    check("to_result", res, 3);
    check("to_delay_min", dly >= TO, 1);
    check("to_delay_max", dly <= TO + 20, 1);
    check("to_drives", {kclk_drive_low, kdata_drive_low}, 0);
    check("to_ready", tx_ready, 1);
    repeat (40) @(negedge clk);

    // Reset asserted while bit 5 is on the line.
    run_frame(8'h5A, 1'b0, 1'b0, 1'b0, 0, 5, bits, inh, tr, res, dly);
    check("rst_result", res, 4);
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (tx_done || tx_ack_err || tx_timeout || busy) cnt++;
    end
    check("rst_quiet_after", cnt, 0);

    run_frame(8'hFF, 1'b0, 1'b0, 1'b0, 0, 0, bits, inh, tr, res, dly);
    check("post_rst_data", bits[8:1], 8'hFF);
    check("post_rst_parity", bits[9], 1);
    check("post_rst_result", res, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/ps2_transmitter.md
Name: ps2_transmitter

Overview:
- Host-to-device PS/2 transmitter. It sends command bytes to the keyboard, such as 0xED (set LEDs), 0xF4 (enable) and 0xFF (reset).
- It sits beside the keyboard receiver on the same kclk/kdata pins and drives them open-drain through pull-low enables.
- It performs the request-to-send sequence, shifts out data, parity and stop bits on device-generated clock edges, and checks the device acknowledge bit.
- `busy` tells the receiver to ignore line activity during a host frame.

Parameters:
- INHIBIT_CYCLES, 12000, clk cycles the host holds kclk low before request-to-send (120 us at 100 MHz).
- TIMEOUT_CYCLES, 200000, maximum clk cycles allowed between consecutive device falling edges (2 ms); also caps the wait after ack.
- FILTER_LEN, 8, number of consecutive identical synchronized samples required before a kclk or kdata level change is accepted.

Ports:
- clk  in  1  system clock (100 MHz nominal)
- rst  in  1  synchronous, active-high reset
- tx_data  in  8  byte to send, LSB first
- tx_valid  in  1  request to send tx_data
- tx_ready  out  1  high only in IDLE; a byte is accepted when tx_valid and tx_ready are both high in the same cycle
- kclk  in  1  raw PS/2 clock pin level
- kdata  in  1  raw PS/2 data pin level
- kclk_drive_low  out  1  1 means pull kclk low; 0 means release (high-Z)
- kdata_drive_low  out  1  1 means pull kdata low; 0 means release
- busy  out  1  high in every state other than IDLE
- tx_done  out  1  one-cycle pulse when a frame completes with a valid ack
- tx_ack_err  out  1  one-cycle pulse when a frame completes but the ack bit is high
- tx_timeout  out  1  one-cycle pulse when a frame is aborted by the watchdog

Behaviour:
- **Input conditioning.** kclk and kdata each pass through a 2-flop synchronizer and then a FILTER_LEN glitch filter.
  - A falling edge of the filtered clock (fclk) is a one-cycle strobe.
  - The filtered data level is fdata.
- **Reset.** Next edge after rst=1:
  - state=IDLE; kclk_drive_low=0, kdata_drive_low=0.
  - tx_ready=1, busy=0; all pulses 0.
  - Counters cleared; filters preset to 1.
  - Reset mid-frame releases both lines on that edge with no error pulse.
- **IDLE.**
  - tx_ready=1.
  - On accept: latch tx_data, compute odd parity (parity = ~^tx_data), clear the cycle counter, go to INHIBIT.
- **INHIBIT.**
  - kclk_drive_low=1, kdata_drive_low=0.
  - After exactly INHIBIT_CYCLES cycles: set kdata_drive_low=1 (start bit), then release kclk one cycle later, go to RTS.
- **RTS.**
  - kclk released, kdata held low; bit index = 0; watchdog cleared.
  - Each fclk falling edge advances the bit index and sets kdata_drive_low for the next bit:
    - edges 1–8: kdata_drive_low = ~data[edge-1]
    - edge 9: kdata_drive_low = ~parity
    - edge 10: kdata_drive_low = 0 (stop bit, line released); go to ACK.
- **ACK.**
  - On the next fclk falling edge, sample fdata: 0 means ack OK, 1 means ack error.
  - Then go to WAIT_IDLE.
- **WAIT_IDLE.**
  - Wait until fclk=1 and fdata=1, then go to IDLE.
  - On entering IDLE, pulse tx_done (ack OK) or tx_ack_err (ack error).
- **Watchdog.**
  - Runs in RTS, ACK and WAIT_IDLE; restarts on each fclk falling edge.
  - Reaching TIMEOUT_CYCLES releases both lines, pulses tx_timeout and goes to IDLE.
- **Handshake rules.**
  - tx_valid while busy is ignored; tx_data need not be held after accept.
  - A new byte can be accepted in the cycle after a done, ack-error or timeout pulse.
- **Line driving.** Outputs never pull kclk low outside INHIBIT and the single transition cycle at the end of INHIBIT.

Test Plan:
- Send 0xED; a device model clocks at 12.5 kHz and acks → kclk low for 12000 cycles; sampled bits start 0, then 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done pulses once; busy falls.
- Send 0x01 → data bits 1,0,0,0,0,0,0,0 and parity 0. Send 0xFF → parity 1. Send 0x00 → parity 1. Each frame ends in tx_done.
- Device holds ack high on 0xF4 → parity 0 is observed, tx_ack_err pulses, tx_done stays 0, state returns to IDLE.
- Device stops clocking after edge 4 → tx_timeout pulses TIMEOUT_CYCLES after edge 4; both drive_low outputs are 0; tx_ready=1.
- Assert rst during bit 5 → next cycle both drive_low=0, busy=0, no pulses. A following 0xFF send completes normally.
- Inject a 3-cycle glitch on kclk during RTS, with FILTER_LEN=8 → no bit advance; frame is still correct. tx_valid pulsed while busy → ignored, only one frame sent.
